// File: rtl/spi_regfile_slave.sv
// spi_regfile_slave: SPI mode-0 register-file slave, fully clk-synchronous.
// Define SPI_REGFILE_READBACK_EN to drive register contents on sdo during read frames.
module spi_regfile_slave #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       cs_n,
  input  logic                       sdi,
  output logic                       sdo,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME_LEN + 2);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state_q;
  logic [2:0] sclk_q;
  logic [1:0] cs_q, sdi_q, init_q;
  logic armed_q;
  logic [FRAME_LEN-1:0] sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic wr_stb_q, frame_err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic sclk_rise, cs_hi, rw, frame_ok;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign cs_hi = cs_q[1];
  assign rw = sr_q[FRAME_LEN-1];
  assign addr = sr_q[DATA_W +: ADDR_W];
  assign data = sr_q[DATA_W-1:0];
  assign frame_ok = cnt_q == CNT_W'(FRAME_LEN) && int'(addr) < NUM_REGS;
  assign regs = regs_q;
  assign wr_stb = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign frame_err = frame_err_q;
  // armed_q stays low until cs_n has really been seen high after reset, so a frame already in flight is skipped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q <= '1;
      sdi_q <= '0;
      init_q <= '0;
      armed_q <= 1'b0;
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      regs_q <= '0;
      wr_stb_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q <= {cs_q[0], cs_n};
      sdi_q <= {sdi_q[0], sdi};
      init_q <= {init_q[0], 1'b1};
      armed_q <= armed_q | (init_q[1] & cs_hi);
      wr_stb_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: if (armed_q && !cs_hi) begin
          state_q <= SHIFT;
          sr_q <= '0;
          cnt_q <= '0;
        end
        SHIFT: if (cs_hi) state_q <= COMMIT;
        else if (sclk_rise) begin
          sr_q <= {sr_q[FRAME_LEN-2:0], sdi_q[1]};
          cnt_q <= cnt_q + CNT_W'(cnt_q != CNT_W'(FRAME_LEN + 1));
        end
        COMMIT: begin
          state_q <= IDLE;
          if (frame_ok && rw) begin
            for (int k = 0; k < NUM_REGS; k++)
              if (int'(addr) == k) regs_q[k*DATA_W +: DATA_W] <= data;
            wr_stb_q <= 1'b1;
            wr_addr_q <= addr;
          end else if (!frame_ok) frame_err_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef SPI_REGFILE_READBACK_EN
  logic sdo_q;
  logic [DATA_W-1:0] out_q, rb_val;
  always_comb begin
    rb_val = '0;
    for (int k = 0; k < NUM_REGS; k++)
      rb_val = int'(sr_q[ADDR_W-1:0]) == k ? regs_q[k*DATA_W +: DATA_W] : rb_val;
  end
  // the falling edge right after the last address bit loads the register and presents its MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdo_q <= 1'b0;
      out_q <= '0;
    end else if (state_q != SHIFT || cs_hi) begin
      sdo_q <= 1'b0;
      out_q <= '0;
    end else if (sclk_q[2] & ~sclk_q[1]) begin
      if (cnt_q == CNT_W'(1 + ADDR_W)) begin
        sdo_q <= ~sr_q[ADDR_W] & rb_val[DATA_W-1];
        out_q <= sr_q[ADDR_W] ? '0 : rb_val << 1;
      end else begin
        sdo_q <= out_q[DATA_W-1];
        out_q <= out_q << 1;
      end
    end
  end
  assign sdo = sdo_q;
`else
  assign sdo = 1'b0;
`endif
endmodule
